// File: rtl/latchn_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : latchn_bank_pkg
//  Description : Shared types, constants and helpers for the latchn_bank
//                capture bank (window FSM state encoding, counter width,
//                channel-select width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package latchn_bank_pkg;

  // Width of the window-length down-counter; OPEN_CYCLES is limited to 1..255.
  localparam int CNT_W = 8;

  // Window controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_e;

  // Select-port width: at least one bit even for a single-channel bank.
  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : latchn_bank_pkg
`default_nettype wire

// File: rtl/latchn_bank_latch_cell.sv
`default_nettype none
// ============================================================================
//  Module      : latch_cell
//  Description : WIDTH-bit level-sensitive latch with an active-high
//                transparent enable and an asynchronous active-high clear.
//                Gate polarity and window logic are resolved by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module latch_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Transparent while enabled, holds otherwise; clear overrides an open gate.
  always_latch begin
    if (clr_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : latch_cell
`default_nettype wire

// File: rtl/latchn_bank.sv
`default_nettype none
// ============================================================================
//  Module      : latchn_bank
//  Description : CHANNELS independent WIDTH-bit level latches, each opened by
//                its own external gate (selectable polarity) or by a clocked
//                window controller that opens one selected channel for
//                OPEN_CYCLES clock cycles and acknowledges with a pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module latchn_bank
  import latchn_bank_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int CHANNELS        = 4,
  parameter int OPEN_CYCLES     = 2,
  parameter bit GATE_ACTIVE_LOW = 1'b1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [WIDTH*CHANNELS-1:0]     D,
  input  logic [CHANNELS-1:0]           G,
  input  logic                          REQ,
  input  logic [chan_w(CHANNELS)-1:0]   CH_SEL,
  output logic                          BUSY,
  output logic                          ACK,
  output logic                          ERR,
  output logic [WIDTH*CHANNELS-1:0]     Q
);

  localparam int              SEL_W    = chan_w(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OPEN_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_chk_channels
    $error("latchn_bank: CHANNELS must be in 1..16");
  end

  if (OPEN_CYCLES < 1 || OPEN_CYCLES > 255) begin : g_chk_open_cycles
    $error("latchn_bank: OPEN_CYCLES must be in 1..255");
  end

  // --------------------------------------------------------------------------
  // Window controller state
  // --------------------------------------------------------------------------
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic               win_q;
  logic               busy_q;
  logic               ack_q;
  logic               err_q;

  // A request is only honoured for a channel that actually exists.
  logic req_valid;
  assign req_valid = (int'(CH_SEL) < CHANNELS);

  // Window FSM. The CLOSE cycle hands back to IDLE but also evaluates REQ on
  // its exiting edge, so a held REQ yields back-to-back windows separated by
  // exactly one CLOSE cycle. REQ seen in OPEN is dropped, never queued.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      win_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE, CLOSE: begin
          if (REQ && req_valid) begin
            sel_q   <= CH_SEL;
            cnt_q   <= CNT_LOAD;
            win_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= OPEN;
          end else begin
            err_q   <= REQ;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        OPEN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            win_q   <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= CLOSE;
          end
        end
        default: begin
          win_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign ACK  = ack_q;
  assign ERR  = err_q;

  // --------------------------------------------------------------------------
  // Per-channel transparency: external gate OR registered window selection.
  // --------------------------------------------------------------------------
  logic [CHANNELS-1:0] gate_act;
  logic [CHANNELS-1:0] chan_open;

  assign gate_act = GATE_ACTIVE_LOW ? ~G : G;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign chan_open[c] = gate_act[c] | (win_q & (sel_q == SEL_W'(c)));

    latch_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clr_i (RST),
      .en_i  (chan_open[c]),
      .d_i   (D[c*WIDTH +: WIDTH]),
      .q_o   (Q[c*WIDTH +: WIDTH])
    );
  end

endmodule : latchn_bank
`default_nettype wire

// File: tb/tb_latchn_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latchn_bank
//  Description : Self-checking bench for latchn_bank. Instance dut uses the
//                default configuration (4 channels, 2-cycle window); instance
//                dut3 uses 3 channels and a 1-cycle window so that an
//                out-of-range select and back-to-back windows can be driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_latchn_bank;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] d;
  logic [3:0]  g;
  logic        req;
  logic [1:0]  ch_sel;
  logic        busy, ack, err;
  logic [31:0] q;

  logic [23:0] d3;
  logic [2:0]  g3;
  logic        req3;
  logic [1:0]  ch_sel3;
  logic        busy3, ack3, err3;
  logic [23:0] q3;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  latchn_bank #(
    .WIDTH (8), .CHANNELS (4), .OPEN_CYCLES (2), .GATE_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK (clk), .RST (rst), .D (d), .G (g), .REQ (req), .CH_SEL (ch_sel),
    .BUSY (busy), .ACK (ack), .ERR (err), .Q (q)
  );

  latchn_bank #(
    .WIDTH (8), .CHANNELS (3), .OPEN_CYCLES (1), .GATE_ACTIVE_LOW (1'b1)
  ) dut3 (
    .CLK (clk), .RST (rst), .D (d3), .G (g3), .REQ (req3), .CH_SEL (ch_sel3),
    .BUSY (busy3), .ACK (ack3), .ERR (err3), .Q (q3)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; g = 4'h0; d = 32'hFFFF_FFFF; req = 1'b0; ch_sel = 2'd0;
    g3 = 3'b000; d3 = 24'hFF_FFFF; req3 = 1'b0; ch_sel3 = 2'd0;
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    step(); step();
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, exp_v); end
    exp_v = sb.pop_front();
    checks++;
    if (q3 !== exp_v[23:0]) begin errors++; $display("FAIL reset_q3 got=%h exp=%h", q3, exp_v[23:0]); end
    checks++;
    if ({busy, ack, err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {busy, ack, err});
    end
    g = 4'hF; g3 = 3'b111;
    #1 rst = 1'b0;
    d = 32'h1234_5678; d3 = 24'h12_3456;
    sb.push_back(32'h0);
    #2;
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL closed_after_reset got=%h exp=%h", q, exp_v); end
  endtask

  task automatic test_gate();
    step();
    g = 4'b1011; d = 32'h00A5_0000;
    sb.push_back(32'h00A5_0000);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL gate_open got=%h exp=%h", q, exp_v); end
    g = 4'hF;
    #1 d = 32'hFF3C_FFFF;
    sb.push_back(32'h00A5_0000);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL gate_hold got=%h exp=%h", q, exp_v); end
  endtask

  task automatic test_window();
    step();
    req = 1'b1; ch_sel = 2'd1; d = 32'h0000_1100;
    step();                                   // edge k: window opens on ch1
    req = 1'b0;
    sb.push_back(32'h00A5_1100);
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL window_open got=%h exp=%h", q, exp_v); end
    d = 32'h0000_2200;
    sb.push_back(32'h00A5_2200);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL window_follow got=%h exp=%h", q, exp_v); end
    sb.push_back(32'd2); sb.push_back(32'd2); sb.push_back(32'd3); sb.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      exp_v = sb.pop_front();
      checks++;
      if ({busy, ack} !== exp_v[1:0]) begin
        errors++; $display("FAIL window_busy_ack cyc=%0d got=%b exp=%b", i, {busy, ack}, exp_v[1:0]);
      end
      if (i == 2) d = 32'h0000_3300;
    end
    sb.push_back(32'h00A5_2200);
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL window_held got=%h exp=%h", q, exp_v); end
  endtask

  task automatic test_err_and_ignore();
    int acks;
    step();
    req3 = 1'b1; ch_sel3 = 2'd3;
    step();
    req3 = 1'b0;
    checks++;
    if ({err3, busy3} !== 2'b10) begin errors++; $display("FAIL err_pulse got=%b exp=10", {err3, busy3}); end
    step();
    checks++;
    if (err3 !== 1'b0) begin errors++; $display("FAIL err_single got=%b exp=0", err3); end
    sb.push_back(32'h0);
    exp_v = sb.pop_front();
    checks++;
    if (q3 !== exp_v[23:0]) begin errors++; $display("FAIL err_q_unchanged got=%h exp=%h", q3, exp_v[23:0]); end

    req = 1'b1; ch_sel = 2'd0; d = 32'h0000_33FF;
    step();                                   // window on ch0
    ch_sel = 2'd3;                            // REQ stays high one more edge, while BUSY
    step();
    req = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 1) begin errors++; $display("FAIL busy_req_ignored acks=%0d exp=1", acks); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle got=%b exp=0", busy); end
    sb.push_back(32'h00A5_22FF);
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL ignore_q got=%h exp=%h", q, exp_v); end
  endtask

  task automatic test_reset_mid_window();
    int seen;
    step();
    req = 1'b1; ch_sel = 2'd0; d = 32'h0000_005A;
    step();
    req = 1'b0;
    #2 rst = 1'b1;
    sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL midrst_q got=%h exp=%h", q, exp_v); end
    checks++;
    if ({busy, ack} !== 2'b00) begin errors++; $display("FAIL midrst_flags got=%b exp=00", {busy, ack}); end
    step(); step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ack === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || q !== 32'h0) begin
      errors++; $display("FAIL midrst_no_ack acks=%0d q=%h exp acks=0 q=0", seen, q);
    end
    req = 1'b1; ch_sel = 2'd0; d = 32'h0000_0077;
    step();                                   // edge k
    req = 1'b0;
    seen = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (ack === 1'b1) begin seen = n; break; end
    end
    checks++;
    if (seen !== 2) begin errors++; $display("FAIL rerequest_ack_cycle got=%0d exp=2", seen); end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rerequest_busy got=%b exp=0", busy); end
    sb.push_back(32'h0000_0077);
    exp_v = sb.pop_front();
    checks++;
    if (q !== exp_v) begin errors++; $display("FAIL rerequest_q got=%h exp=%h", q, exp_v); end
  endtask

  task automatic test_back_to_back();
    step();
    req3 = 1'b1; ch_sel3 = 2'd0; d3 = 24'h00_0040;
    step();                                   // first one-cycle window
    for (int i = 0; i < 6; i++) sb.push_back((i % 2 == 0) ? 32'd5 : 32'd3);  // {win,ack,busy}
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      exp_v = sb.pop_front();
      checks++;
      if ({dut3.win_q, ack3, busy3} !== exp_v[2:0]) begin
        errors++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, {dut3.win_q, ack3, busy3}, exp_v[2:0]);
      end
      d3 = 24'h00_0041 + 24'(i);
    end
    req3 = 1'b0;
    step();
    checks++;
    if (busy3 !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy3); end
    // Last open cycle was i=4; the value driven after it (0x45) was captured before win dropped.
    sb.push_back(32'h0000_0045);
    exp_v = sb.pop_front();
    checks++;
    if (q3 !== exp_v[23:0]) begin errors++; $display("FAIL b2b_q got=%h exp=%h", q3, exp_v[23:0]); end
  endtask

  initial begin
    test_reset();
    test_gate();
    test_window();
    test_err_and_ignore();
    test_reset_mid_window();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule : tb_latchn_bank
`default_nettype wire
